// File: rtl/ysyx_trap_ctrl_pkg.sv
// ysyx_trap_ctrl_pkg: CSR addresses, mstatus fields, cause codes and FSM encodings for trap sequencing
package ysyx_trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam int MIE_BIT    = 3;
  localparam int MPIE_BIT   = 7;
  localparam int MPP_LO_BIT = 11;
  localparam int MPP_HI_BIT = 12;
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_EBREAK  = 4'd3;
  localparam logic [3:0] EXC_ECALL_M = 4'd11;
  localparam logic [3:0] IRQ_MTI     = 4'd7;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STATUS = 3'd3,
    M_STATUS = 3'd4,
    REDIR    = 3'd5
  } state_e;
  typedef enum logic [1:0] {
    K_TRAP = 2'd0,
    K_IRQ  = 2'd1,
    K_MRET = 2'd2
  } kind_e;
endpackage

// File: rtl/ysyx_trap_tvec.sv
// ysyx_trap_tvec: trap-entry target from mtvec; vectored offset only for interrupts, modes 2/3 act as direct
module ysyx_trap_tvec
  import ysyx_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic            is_irq,
  input  logic [3:0]      cause_code,
  output logic [XLEN-1:0] target
);
  logic [XLEN-1:0] base;
  assign base = mtvec & ~XLEN'(3);
  assign target = (mtvec[1:0] == MTVEC_VECTORED && is_irq) ? base + XLEN'({cause_code, 2'b00}) : base;
endmodule

// File: rtl/ysyx_trap_ctrl.sv
// ysyx_trap_ctrl: sequences trap entry / mret over the CSR write port; timer irq under YSYX_TRAP_IRQ_EN
module ysyx_trap_ctrl
  import ysyx_trap_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid,
  input  logic [3:0]        trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  output logic              trap_ready,
  input  logic              mret_valid,
`ifdef YSYX_TRAP_IRQ_EN
  input  logic              irq_mtip,
  input  logic [XLEN-1:0]   irq_pc,
`endif
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              csr_wen,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              busy,
  output logic              redir_valid,
  output logic [XLEN-1:0]   redir_pc,
  input  logic              redir_ready
);
  state_e          state;
  kind_e           kind;
  logic [XLEN-1:0] cause, nxt_epc, st_entry, st_mret, tvec_pc, irq_epc;
  logic            irq_pend;
`ifdef YSYX_TRAP_IRQ_EN
  assign irq_pend = irq_mtip & mstatus_i[MIE_BIT];
  assign irq_epc  = irq_pc;
`else
  assign irq_pend = 1'b0;
  assign irq_epc  = '0;
`endif
  assign trap_ready = (state == IDLE) && !rst;
  assign busy       = state != IDLE;
  assign nxt_epc    = (irq_pend ? irq_epc : trap_pc) & ~XLEN'(3);
  always_comb begin
    st_entry = mstatus_i;
    st_entry[MPIE_BIT] = mstatus_i[MIE_BIT];
    st_entry[MIE_BIT] = 1'b0;
    st_entry[MPP_HI_BIT:MPP_LO_BIT] = 2'b11;
    st_mret = mstatus_i;
    st_mret[MIE_BIT] = mstatus_i[MPIE_BIT];
    st_mret[MPIE_BIT] = 1'b1;
    st_mret[MPP_HI_BIT:MPP_LO_BIT] = 2'b11;
  end
  ysyx_trap_tvec #(.XLEN(XLEN)) u_tvec (
    .mtvec      (mtvec_i),
    .is_irq     (kind == K_IRQ),
    .cause_code (cause[3:0]),
    .target     (tvec_pc)
  );
  // csr_* are precomputed on the transition into each write state so they are pure registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      kind        <= K_TRAP;
      cause       <= '0;
      csr_wen     <= 1'b0;
      csr_waddr   <= '0;
      csr_wdata   <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      csr_wen   <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      case (state)
        IDLE: begin
          if (irq_pend || trap_valid) begin
            state     <= W_EPC;
            kind      <= irq_pend ? K_IRQ : K_TRAP;
            cause     <= irq_pend ? {1'b1, (XLEN-1)'(IRQ_MTI)} : XLEN'(trap_cause);
            csr_wen   <= 1'b1;
            csr_waddr <= CSR_AW'(CSR_MEPC);
            csr_wdata <= nxt_epc;
          end else if (mret_valid) begin
            state     <= M_STATUS;
            kind      <= K_MRET;
            csr_wen   <= 1'b1;
            csr_waddr <= CSR_AW'(CSR_MSTATUS);
            csr_wdata <= st_mret;
          end
        end
        W_EPC: begin
          state     <= W_CAUSE;
          csr_wen   <= 1'b1;
          csr_waddr <= CSR_AW'(CSR_MCAUSE);
          csr_wdata <= cause;
        end
        W_CAUSE: begin
          state     <= W_STATUS;
          csr_wen   <= 1'b1;
          csr_waddr <= CSR_AW'(CSR_MSTATUS);
          csr_wdata <= st_entry;
        end
        W_STATUS: begin
          state       <= REDIR;
          redir_valid <= 1'b1;
          redir_pc    <= tvec_pc;
        end
        M_STATUS: begin
          state       <= REDIR;
          redir_valid <= 1'b1;
          redir_pc    <= mepc_i & ~XLEN'(3);
        end
        REDIR: begin
          if (redir_ready) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_trap_ctrl.sv
// tb_ysyx_trap_ctrl: directed self-checking bench for ysyx_trap_ctrl (irq steps need YSYX_TRAP_IRQ_EN)
module tb_ysyx_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst, trap_valid, mret_valid, redir_ready;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc, mstatus_i, mtvec_i, mepc_i;
  logic        trap_ready, csr_wen, busy, redir_valid;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redir_pc;
`ifdef YSYX_TRAP_IRQ_EN
  logic        irq_mtip;
  logic [31:0] irq_pc;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ysyx_trap_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_ready  (trap_ready),
    .mret_valid  (mret_valid),
`ifdef YSYX_TRAP_IRQ_EN
    .irq_mtip    (irq_mtip),
    .irq_pc      (irq_pc),
`endif
    .mstatus_i   (mstatus_i),
    .mtvec_i     (mtvec_i),
    .mepc_i      (mepc_i),
    .csr_wen     (csr_wen),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .busy        (busy),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ready (redir_ready)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    chk({tag, "_wen"}, 32'(csr_wen), 32'd1);
    chk({tag, "_waddr"}, 32'(csr_waddr), 32'(addr));
    chk({tag, "_wdata"}, csr_wdata, data);
  endtask
  task automatic chk_idle_port(input string tag);
    chk({tag, "_wen"}, 32'(csr_wen), 32'd0);
    chk({tag, "_waddr"}, 32'(csr_waddr), 32'd0);
    chk({tag, "_wdata"}, csr_wdata, 32'd0);
  endtask
  initial begin
    rst = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0; redir_ready = 1'b0;
    trap_cause = 4'd0; trap_pc = 32'd0; mstatus_i = 32'd0; mtvec_i = 32'd0; mepc_i = 32'd0;
`ifdef YSYX_TRAP_IRQ_EN
    irq_mtip = 1'b0; irq_pc = 32'd0;
`endif
    tick(); tick();
    chk("rst_ready", 32'(trap_ready), 32'd0);
    chk_idle_port("rst");
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(redir_valid), 32'd0);
    chk("rst_rpc", redir_pc, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready", 32'(trap_ready), 32'd1);
    // ecall
    mtvec_i = 32'h8000_0200; mstatus_i = 32'h8;
    trap_valid = 1'b1; trap_cause = 4'd11; trap_pc = 32'h8000_0104;
    tick();
    trap_valid = 1'b0;
    chk_write("ecall_epc", 12'h341, 32'h8000_0104);
    chk("ecall_busy", 32'(busy), 32'd1);
    chk("ecall_ready", 32'(trap_ready), 32'd0);
    tick();
    chk_write("ecall_cause", 12'h342, 32'h0000_000B);
    tick();
    chk_write("ecall_status", 12'h300, 32'h0000_1880);
    mstatus_i = 32'h1880;
    tick();
    chk("ecall_rvalid", 32'(redir_valid), 32'd1);
    chk("ecall_rpc", redir_pc, 32'h8000_0200);
    chk_idle_port("ecall_redir");
    // IFU stalls the redirect; a new trap waits
    trap_valid = 1'b1; trap_cause = 4'd3; trap_pc = 32'h8000_0300;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rvalid", 32'(redir_valid), 32'd1);
      chk("stall_rpc", redir_pc, 32'h8000_0200);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_ready", 32'(trap_ready), 32'd0);
      chk("stall_wen", 32'(csr_wen), 32'd0);
    end
    trap_valid = 1'b0;
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("ecall_done_rvalid", 32'(redir_valid), 32'd0);
    chk("ecall_done_busy", 32'(busy), 32'd0);
    chk("ecall_done_ready", 32'(trap_ready), 32'd1);
    // mret
    mepc_i = 32'h8000_0108; mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    chk_write("mret_status", 12'h300, 32'h0000_1888);
    mstatus_i = 32'h1888;
    tick();
    chk("mret_rvalid", 32'(redir_valid), 32'd1);
    chk("mret_rpc", redir_pc, 32'h8000_0108);
    chk_idle_port("mret_redir");
    redir_ready = 1'b1;
    tick();
    chk("mret_done_busy", 32'(busy), 32'd0);
    // redir_ready stays high in IDLE and must be ignored
    tick();
    chk("idle_rready_rvalid", 32'(redir_valid), 32'd0);
    chk("idle_rready_busy", 32'(busy), 32'd0);
    redir_ready = 1'b0;
    // illegal instruction at a misaligned pc, vectored mtvec stays direct for exceptions
    mtvec_i = 32'h8000_0201; mstatus_i = 32'h0;
    trap_valid = 1'b1; trap_cause = 4'd2; trap_pc = 32'h8000_0203;
    tick();
    trap_valid = 1'b0;
    chk_write("ill_epc", 12'h341, 32'h8000_0200);
    tick();
    chk_write("ill_cause", 12'h342, 32'h0000_0002);
    tick();
    chk_write("ill_status", 12'h300, 32'h0000_1800);
    tick();
    chk("ill_rpc", redir_pc, 32'h8000_0200);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    // reset lands after the mepc write: later writes are dropped
    mtvec_i = 32'h8000_0200; mstatus_i = 32'h8;
    trap_valid = 1'b1; trap_cause = 4'd11; trap_pc = 32'h8000_0400;
    tick();
    trap_valid = 1'b0;
    chk_write("rstmid_epc", 12'h341, 32'h8000_0400);
    rst = 1'b1;
    tick();
    chk_idle_port("rstmid");
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rvalid", 32'(redir_valid), 32'd0);
    chk("rstmid_rpc", redir_pc, 32'd0);
    chk("rstmid_ready_in_rst", 32'(trap_ready), 32'd0);
    rst = 1'b0; #1;
    chk("rstmid_ready", 32'(trap_ready), 32'd1);
    tick();
    chk("rstmid_no_write", 32'(csr_wen), 32'd0);
`ifdef YSYX_TRAP_IRQ_EN
    // simultaneous irq and ecall: irq wins, ecall held and taken afterwards
    mtvec_i = 32'h8000_0201; mstatus_i = 32'h8;
    irq_mtip = 1'b1; irq_pc = 32'h8000_0010;
    trap_valid = 1'b1; trap_cause = 4'd11; trap_pc = 32'h8000_0104;
    tick();
    chk_write("irq_epc", 12'h341, 32'h8000_0010);
    tick();
    chk_write("irq_cause", 12'h342, 32'h8000_0007);
    tick();
    chk_write("irq_status", 12'h300, 32'h0000_1880);
    irq_mtip = 1'b0; mstatus_i = 32'h1880;
    tick();
    chk("irq_rpc", redir_pc, 32'h8000_021C);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("irq_done_ready", 32'(trap_ready), 32'd1);
    tick();
    trap_valid = 1'b0;
    chk_write("held_epc", 12'h341, 32'h8000_0104);
    tick();
    chk_write("held_cause", 12'h342, 32'h0000_000B);
    tick(); tick();
    chk("held_rpc", redir_pc, 32'h8000_0200);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    // MIE clear masks the timer
    irq_mtip = 1'b1; mstatus_i = 32'h1880;
    tick();
    chk("masked_ready", 32'(trap_ready), 32'd1);
    chk("masked_wen", 32'(csr_wen), 32'd0);
    tick();
    chk("masked_busy", 32'(busy), 32'd0);
    irq_mtip = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
